sd_spi: RTL and testbench

SD_SPI -- requirements
Module: sd_spi

---
 rtl/sd_spi_pkg.sv | 22 ++
 rtl/sd_spi_clkgen.sv | 31 +++
 rtl/sd_spi.sv | 159 +++++++++++++++
 tb/tb_sd_spi.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI master: command encodings,
// FSM states and the number of SCLK half-periods for each sequence.
package sd_spi_pkg;

  typedef enum logic [1:0] {
    CMD_XFER  = 2'd0,
    CMD_INIT  = 2'd1,
    CMD_CS_LO = 2'd2,
    CMD_CS_HI = 2'd3
  } sd_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    INIT = 2'd2
  } sd_state_e;

  // One byte = 8 pulses = 16 half-periods; init = 80 pulses = 160 half-periods
  localparam logic [7:0] XFER_HALVES = 8'd16;
  localparam logic [7:0] INIT_HALVES = 8'd160;

endpackage

// File: rtl/sd_spi_clkgen.sv
// SCLK half-period tick generator. While enabled, tick_o pulses once every
// div_i system clocks; the count restarts from zero whenever disabled so the
// first tick lands exactly div_i clocks after enable rises.
module sd_spi_clkgen #(
  parameter int DIV_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == (div_i - ONE));

  // Divider counter: wraps on each tick, held at zero while disabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!en_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + ONE;
    end
  end

endmodule

// File: rtl/sd_spi.sv
// SD-card SPI master (mode 0, MSB first) with init clocking, chip-select
// control and an idle timeout flag.
// Optional feature macro: SD_SLOW_INIT_EN -- when defined the init sequence
// clocks SCLK with INIT_DIV half-periods instead of SCLK_DIV.
module sd_spi
  import sd_spi_pkg::*;
#(
  parameter int SCLK_DIV       = 2,
  parameter int INIT_DIV       = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sd_signal,
  input  logic [1:0] sd_cmd,
  input  logic [7:0] sd_out,
  output logic [7:0] sd_din,
  output logic       sd_busy,
  output logic       sd_timeout,
  output logic       SPI_CS,
  output logic       SPI_SCLK,
  input  logic       SPI_MISO,
  output logic       SPI_MOSI
);

  // Divider counter is sized for the larger of the two half-periods
  localparam int MAX_DIV = (INIT_DIV > SCLK_DIV) ? INIT_DIV : SCLK_DIV;
  localparam int DIV_W   = $clog2(MAX_DIV + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  sd_state_e        state_q;
  logic             busy_q;
  logic             cs_q;
  logic             sclk_q;
  logic             mosi_q;
  logic [7:0]       din_q;
  logic [7:0]       shreg_q;
  logic             miso_q;
  logic [7:0]       hcnt_q;
  logic [TO_W-1:0]  idle_q;
  logic [TO_W-1:0]  idle_d;
  logic [DIV_W-1:0] div_d;
  logic             accept;
  logic             tick;

  // Commands are only taken while not busy; strobes during a command are dropped
  assign accept = sd_signal && !busy_q;

`ifdef SD_SLOW_INIT_EN
  assign div_d = (state_q == INIT) ? DIV_W'(INIT_DIV) : DIV_W'(SCLK_DIV);
`else
  assign div_d = DIV_W'(SCLK_DIV);
`endif

  sd_spi_clkgen #(
    .DIV_W (DIV_W)
  ) u_clkgen (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .en_i   (state_q != IDLE),
    .div_i  (div_d),
    .tick_o (tick)
  );

  // Command FSM: shift register, SCLK/MOSI/CS generation and busy flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      din_q   <= 8'hFF;
      shreg_q <= 8'hFF;
      miso_q  <= 1'b1;
      hcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (accept) begin
            busy_q <= 1'b1;
            hcnt_q <= '0;
            sclk_q <= 1'b0;
            case (sd_cmd_e'(sd_cmd))
              CMD_XFER: begin
                state_q <= XFER;
                shreg_q <= sd_out;
                mosi_q  <= sd_out[7];
              end
              CMD_INIT: begin
                state_q <= INIT;
                cs_q    <= 1'b1;
                mosi_q  <= 1'b1;
              end
              CMD_CS_LO: cs_q <= 1'b0;
              default:   cs_q <= 1'b1;
            endcase
          end
        end
        XFER: begin
          // Final clock after the last falling edge: publish the byte
          if (hcnt_q == XFER_HALVES) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            din_q   <= shreg_q;
          end else if (tick) begin
            hcnt_q <= hcnt_q + 8'd1;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              miso_q <= SPI_MISO;
            end else begin
              shreg_q <= {shreg_q[6:0], miso_q};
              mosi_q  <= (hcnt_q == XFER_HALVES - 8'd1) ? 1'b1 : shreg_q[6];
            end
          end
        end
        INIT: begin
          if (hcnt_q == INIT_HALVES) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tick) begin
            hcnt_q <= hcnt_q + 8'd1;
            sclk_q <= ~sclk_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Idle counter next state: clear on accept, saturating count while not busy
  always_comb begin
    idle_d = idle_q;
    if (accept) begin
      idle_d = '0;
    end else if (!busy_q && (idle_q < TO_MAX)) begin
      idle_d = idle_q + TO_W'(1);
    end
  end

  // Idle counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign sd_timeout = (idle_q >= TO_MAX);
  assign sd_busy    = busy_q;
  assign sd_din     = din_q;
  assign SPI_CS     = cs_q;
  assign SPI_SCLK   = sclk_q;
  assign SPI_MOSI   = mosi_q;

endmodule

// File: tb/tb_sd_spi.sv
// Self-checking bench for sd_spi with default parameters. Expected bytes,
// MOSI streams and latencies are queued when a command is issued and popped
// when the command completes.
module tb_sd_spi;

  localparam int XFER_HALF = 2;
`ifdef SD_SLOW_INIT_EN
  localparam int INIT_HALF = 32;
`else
  localparam int INIT_HALF = 2;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       sd_signal = 1'b0;
  logic [1:0] sd_cmd = 2'd0;
  logic [7:0] sd_out = 8'h00;
  logic [7:0] sd_din;
  logic       sd_busy;
  logic       sd_timeout;
  logic       SPI_CS;
  logic       SPI_SCLK;
  logic       SPI_MISO;
  logic       SPI_MOSI;

  int tests = 0;
  int fails = 0;

  // Monitor state (each variable written by exactly one process)
  int   rises = 0;
  int   not_hi_r = 0;
  int   not_hi_f = 0;
  logic mosi_hist[$];
  time  rise_t[$];
  time  fall_t[$];

  // Slave model state (written only from the stimulus process)
  logic [7:0] miso_pat = 8'hFF;
  int         miso_base = 0;
  int         miso_rel;
  logic [7:0] miso_sh;

  // Scoreboard
  logic [7:0] exp_din_q[$];
  logic [7:0] exp_mosi_q[$];
  int         exp_lat_q[$];

  always #5 clock = ~clock;

  sd_spi dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sd_signal  (sd_signal),
    .sd_cmd     (sd_cmd),
    .sd_out     (sd_out),
    .sd_din     (sd_din),
    .sd_busy    (sd_busy),
    .sd_timeout (sd_timeout),
    .SPI_CS     (SPI_CS),
    .SPI_SCLK   (SPI_SCLK),
    .SPI_MISO   (SPI_MISO),
    .SPI_MOSI   (SPI_MOSI)
  );

  // Slave presents the next MISO bit right after each SCLK rise
  assign miso_rel = rises - miso_base;
  assign miso_sh  = miso_pat << miso_rel;
  assign SPI_MISO = (miso_rel >= 0 && miso_rel < 8) ? miso_sh[7] : 1'b1;

  always @(posedge SPI_SCLK) begin
    rises++;
    mosi_hist.push_back(SPI_MOSI);
    rise_t.push_back($time);
    if (SPI_CS !== 1'b1 || SPI_MOSI !== 1'b1) not_hi_r++;
  end

  always @(negedge SPI_SCLK) begin
    fall_t.push_back($time);
    if (SPI_CS !== 1'b1 || SPI_MOSI !== 1'b1) not_hi_f++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Issue one strobe; returns just after the strobe clock edge
  task automatic start_cmd(input logic [1:0] c, input logic [7:0] d, input logic [7:0] pat);
    @(negedge clock);
    miso_pat  = pat;
    miso_base = rises;
    sd_cmd    = c;
    sd_out    = d;
    sd_signal = 1'b1;
    @(posedge clock);
    #1;
    sd_signal = 1'b0;
  endtask

  // Wait for busy to drop; lat = clocks after strobe edge, -1 on budget expiry
  task automatic wait_done(input int budget, input int inject, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clock);
      #1;
      sd_signal = 1'b0;
      if (!sd_busy) begin
        lat = n;
        break;
      end
      if (n == inject) begin
        sd_signal = 1'b1;
        sd_cmd    = 2'd2;
        sd_out    = 8'h00;
      end
    end
    sd_signal = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    tests++; if (SPI_CS !== 1'b1) begin fails++; $display("FAIL rst_cs: got %b want 1", SPI_CS); end
    tests++; if (SPI_SCLK !== 1'b0) begin fails++; $display("FAIL rst_sclk: got %b want 0", SPI_SCLK); end
    tests++; if (SPI_MOSI !== 1'b1) begin fails++; $display("FAIL rst_mosi: got %b want 1", SPI_MOSI); end
    tests++; if (sd_din !== 8'hFF) begin fails++; $display("FAIL rst_din: got %h want ff", sd_din); end
    tests++; if (sd_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", sd_busy); end
    tests++; if (sd_timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout: got %b want 0", sd_timeout); end
    repeat (3) @(posedge clock);
  endtask

  task automatic test_timeout();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4095) @(posedge clock);
    #1;
    tests++; if (sd_timeout !== 1'b0) begin fails++; $display("FAIL timeout_early: got %b want 0", sd_timeout); end
    @(posedge clock);
    #1;
    tests++; if (sd_timeout !== 1'b1) begin fails++; $display("FAIL timeout_set: got %b want 1", sd_timeout); end
    tests++; if (SPI_CS !== 1'b1) begin fails++; $display("FAIL timeout_cs: got %b want 1", SPI_CS); end
    tests++; if (sd_din !== 8'hFF) begin fails++; $display("FAIL timeout_din: got %h want ff", sd_din); end
  endtask

  task automatic test_cs_lo();
    start_cmd(2'd2, 8'h00, 8'hFF);
    tests++; if (SPI_CS !== 1'b0) begin fails++; $display("FAIL cslo_cs: got %b want 0", SPI_CS); end
    tests++; if (sd_busy !== 1'b1) begin fails++; $display("FAIL cslo_busy1: got %b want 1", sd_busy); end
    tests++; if (sd_timeout !== 1'b0) begin fails++; $display("FAIL cslo_timeout_clr: got %b want 0", sd_timeout); end
    @(posedge clock);
    #1;
    tests++; if (sd_busy !== 1'b0) begin fails++; $display("FAIL cslo_busy2: got %b want 0", sd_busy); end
    tests++; if (SPI_CS !== 1'b0) begin fails++; $display("FAIL cslo_hold: got %b want 0", SPI_CS); end
  endtask

  task automatic test_xfer(input string name, input logic [7:0] d, input logic [7:0] pat, input int inject);
    int rb;
    int lat;
    logic [7:0] m;
    logic [7:0] e;
    rb = rises;
    start_cmd(2'd0, d, pat);
    exp_din_q.push_back(pat);
    exp_mosi_q.push_back(d);
    exp_lat_q.push_back(16 * XFER_HALF + 1);
    wait_done(400, inject, lat);
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (rb + i < mosi_hist.size()) m = {m[6:0], mosi_hist[rb + i]};
      else m = {m[6:0], 1'bx};
    end
    e = exp_din_q.pop_front();
    tests++; if (sd_din !== e) begin fails++; $display("FAIL %s_din: got %h want %h", name, sd_din, e); end
    e = exp_mosi_q.pop_front();
    tests++; if (m !== e) begin fails++; $display("FAIL %s_mosi: got %h want %h", name, m, e); end
    tests++; if (lat != exp_lat_q[0]) begin fails++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat_q[0]); end
    void'(exp_lat_q.pop_front());
    tests++; if (rises - rb != 8) begin fails++; $display("FAIL %s_pulses: got %0d want 8", name, rises - rb); end
    tests++; if (SPI_SCLK !== 1'b0 || SPI_MOSI !== 1'b1) begin
      fails++; $display("FAIL %s_idle_lines: got sclk=%b mosi=%b want 0/1", name, SPI_SCLK, SPI_MOSI);
    end
  endtask

  task automatic test_init();
    int rb;
    int fb;
    int nr;
    int nf;
    int lat;
    time half;
    rb = rises;
    fb = fall_t.size();
    nr = not_hi_r;
    nf = not_hi_f;
    start_cmd(2'd1, 8'h00, 8'hFF);
    wait_done(160 * INIT_HALF + 200, -1, lat);
    tests++; if (lat < 0) begin fails++; $display("FAIL init_done: busy still high, got %0d want >0", lat); end
    tests++; if (rises - rb != 80) begin fails++; $display("FAIL init_pulses: got %0d want 80", rises - rb); end
    tests++; if ((not_hi_r - nr) + (not_hi_f - nf) != 0) begin
      fails++; $display("FAIL init_cs_mosi_high: got %0d bad edges want 0", (not_hi_r - nr) + (not_hi_f - nf));
    end
    half = 0;
    if (rise_t.size() > rb && fall_t.size() > fb) half = fall_t[fb] - rise_t[rb];
    tests++; if (half != INIT_HALF * 10) begin fails++; $display("FAIL init_half_period: got %0t want %0d", half, INIT_HALF * 10); end
    tests++; if (SPI_CS !== 1'b1) begin fails++; $display("FAIL init_cs_after: got %b want 1", SPI_CS); end
    tests++; if (sd_din !== 8'h3C) begin fails++; $display("FAIL init_din_kept: got %h want 3c", sd_din); end
  endtask

  task automatic test_ignore();
    test_xfer("ignore", 8'hFF, 8'hFF, 5);
    tests++; if (SPI_CS !== 1'b1) begin fails++; $display("FAIL ignore_cs: got %b want 1", SPI_CS); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tx[4];
    logic [7:0] rx[4];
    tx[0] = 8'h12;                 rx[0] = 8'hC3;
    tx[1] = 8'(($urandom % 256));  rx[1] = 8'(($urandom % 256));
    tx[2] = 8'h7E;                 rx[2] = 8'h81;
    tx[3] = 8'h00;                 rx[3] = 8'h5A;
    for (int k = 0; k < 4; k++) test_xfer("b2b", tx[k], rx[k], -1);
  endtask

  task automatic test_reset_mid();
    int rb;
    int after;
    rb = rises;
    start_cmd(2'd0, 8'h96, 8'h0F);
    for (int n = 0; n < 400; n++) begin
      if (rises - rb >= 4) break;
      @(posedge clock);
    end
    #3 reset_n = 1'b0;
    #1;
    tests++; if (SPI_SCLK !== 1'b0) begin fails++; $display("FAIL midrst_sclk: got %b want 0", SPI_SCLK); end
    tests++; if (SPI_CS !== 1'b1) begin fails++; $display("FAIL midrst_cs: got %b want 1", SPI_CS); end
    tests++; if (SPI_MOSI !== 1'b1) begin fails++; $display("FAIL midrst_mosi: got %b want 1", SPI_MOSI); end
    tests++; if (sd_din !== 8'hFF) begin fails++; $display("FAIL midrst_din: got %h want ff", sd_din); end
    tests++; if (sd_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", sd_busy); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    after = rises;
    repeat (40) @(posedge clock);
    #1;
    tests++; if (rises != after || sd_busy !== 1'b0 || sd_din !== 8'hFF) begin
      fails++; $display("FAIL midrst_aborted: got pulses=%0d busy=%b din=%h want 0/0/ff", rises - after, sd_busy, sd_din);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_cs_lo();
    test_xfer("xfer_a5", 8'hA5, 8'h3C, -1);
    test_init();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
